cp0_int_ctrl: RTL and testbench

- CP0 interrupt controller that consumes the level-sensitive timer_int produced by the Compare register.
- Also consumes five external hardware interrupt lines and two software interrupt bits.
- Holds the Status, Cause and EPC registers.
- Runs the request/acknowledge handshake with the pipeline for interrupt entry, and the ERET return redirect.

---
 rtl/cp0_int_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cp0_int_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: Status/Cause/EPC registers, hw_int synchronizer,
// interrupt request/acknowledge handshake with the pipeline and ERET redirect.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   timer_int, hw_int   interrupt sources (timer synchronous, hw_int asynchronous)
//   reg_we/reg_addr/wdata/rdata  MTC0 write port, combinational MFC0 read
//   pc_in, bd_in        interrupt point PC and branch-delay flag
//   int_req, int_ack    interrupt request handshake
//   eret                exception return retiring
//   redirect_valid/pc   one-cycle fetch redirect
`timescale 1ns/1ps
module cp0_int_ctrl #(
    parameter logic [31:0] VECTOR      = 32'h0000_0180,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_int,
    input  logic [4:0]  hw_int,
    input  logic        reg_we,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] pc_in,
    input  logic        bd_in,
    output logic        int_req,
    input  logic        int_ack,
    input  logic        eret,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int unsigned HW_W = 5;
    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t state, state_d;

    logic [SYNC_STAGES-1:0][HW_W-1:0] sync_q;
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip_hw;   // IP[7:2]: timer + synchronized hw_int
    logic [1:0]  cause_sw;      // IP[1:0]: software bits
    logic [31:0] epc;

    logic        pending;
    logic        take_int;
    logic        do_ret;
    logic        int_req_d;
    logic        redirect_valid_d;
    logic [31:0] redirect_pc_d;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;

    logic unused_wdata;
    assign unused_wdata = ^{wdata[31:16], wdata[7:2]};

    assign wr_status = reg_we && (reg_addr == ADDR_STATUS);
    assign wr_cause  = reg_we && (reg_addr == ADDR_CAUSE);
    assign wr_epc    = reg_we && (reg_addr == ADDR_EPC);

    assign pending = (|({cause_ip_hw, cause_sw} & status_im)) & status_ie & ~status_exl;

    // Combinational register read; writes become visible after the edge
    always_comb begin
        rdata = '0;
        case (reg_addr)
            ADDR_STATUS: rdata = {16'h0, status_im, 6'h0, status_exl, status_ie};
            ADDR_CAUSE:  rdata = {cause_bd, 15'h0, cause_ip_hw, cause_sw, 8'h0};
            ADDR_EPC:    rdata = epc;
            default:     rdata = '0;
        endcase
    end

    // Next-state and registered-output logic; an ack in REQ beats everything
    always_comb begin
        state_d          = state;
        int_req_d        = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc;
        take_int         = 1'b0;
        do_ret           = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_d   = REQ;
                    int_req_d = 1'b1;
                end
            end
            REQ: begin
                if (int_ack) begin
                    take_int = 1'b1;
                    state_d  = SERVICE;
                end else if (pending) begin
                    int_req_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVICE: state_d = SERVICE;
            default: state_d = IDLE;
        endcase
        if (!take_int && eret && status_exl) begin
            do_ret    = 1'b1;
            state_d   = IDLE;
            int_req_d = 1'b0;
        end
        if (take_int) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = VECTOR;
        end else if (do_ret) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = epc;
        end
    end

    // State register and handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            int_req        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_d;
            int_req        <= int_req_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
        end
    end

    // hw_int synchronizer chain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= hw_int;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Status / Cause / EPC; hardware events override software writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_im   <= '0;
            status_exl  <= 1'b0;
            status_ie   <= 1'b0;
            cause_bd    <= 1'b0;
            cause_ip_hw <= '0;
            cause_sw    <= '0;
            epc         <= '0;
        end else begin
            cause_ip_hw <= {timer_int, sync_q[SYNC_STAGES-1]};
            if (wr_status) begin
                status_im  <= wdata[15:8];
                status_exl <= wdata[1];
                status_ie  <= wdata[0];
            end
            if (wr_cause) begin
                cause_sw <= wdata[9:8];
            end
            if (wr_epc) begin
                epc <= wdata;
            end
            if (take_int) begin
                status_exl <= 1'b1;
                cause_bd   <= bd_in;
                epc        <= bd_in ? (pc_in - 32'd4) : pc_in;
            end else if (do_ret) begin
                status_exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Self-checking bench for cp0_int_ctrl: directed scenarios plus randomized
// interrupt entry/return, with redirect targets checked through a scoreboard.
`timescale 1ns/1ps
module tb_cp0_int_ctrl;

    localparam logic [31:0] VEC = 32'h0000_0180;
    localparam logic [4:0]  A_ST = 5'd12;
    localparam logic [4:0]  A_CA = 5'd13;
    localparam logic [4:0]  A_EP = 5'd14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        timer_int = 1'b0;
    logic [4:0]  hw_int = '0;
    logic        reg_we = 1'b0;
    logic [4:0]  reg_addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [31:0] pc_in = '0;
    logic        bd_in = 1'b0;
    logic        int_req;
    logic        int_ack = 1'b0;
    logic        eret = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    cp0_int_ctrl #(.VECTOR(VEC), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .timer_int(timer_int), .hw_int(hw_int),
        .reg_we(reg_we), .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata),
        .pc_in(pc_in), .bd_in(bd_in), .int_req(int_req), .int_ack(int_ack),
        .eret(eret), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every redirect pulse must match the oldest expected target
    always @(negedge clk) begin
        if (rst && redirect_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL redirect_unexpected: got pc %h with nothing expected", redirect_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (redirect_pc !== e) begin
                    bad++;
                    $display("FAIL redirect_pc: got %h expected %h", redirect_pc, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_we = 1'b1; reg_addr = a; wdata = d;
        cyc();
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        reg_addr = a;
        #1;
        d = rdata;
    endtask

    task automatic chk_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    // Cycles until int_req rises, -1 on timeout
    task automatic wait_req(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            cyc();
            if (int_req) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic ack(input logic [31:0] pc, input logic bd);
        pc_in = pc; bd_in = bd; int_ack = 1'b1;
        exp_q.push_back(VEC);
        cyc();
        int_ack = 1'b0;
    endtask

    task automatic do_eret(input logic [31:0] target, input logic expect_redirect);
        eret = 1'b1;
        if (expect_redirect) exp_q.push_back(target);
        cyc();
        eret = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] d;
        logic [31:0] m_epc;
        logic [31:0] pc;
        logic        bd;
        logic        use_timer;

        // 1. reset with sources active
        hw_int = 5'h1F; timer_int = 1'b1;
        #12;
        chk_reg("rst_status", A_ST, 32'h0);
        chk_reg("rst_cause", A_CA, 32'h0);
        chk_reg("rst_epc", A_EP, 32'h0);
        check("rst_int_req", 32'(int_req), 32'h0);
        check("rst_redirect", 32'(redirect_valid), 32'h0);
        cyc();
        rst = 1'b1;
        repeat (6) cyc();
        check("no_req_ie0", 32'(int_req), 32'h0);
        chk_reg("cause_sources", A_CA, 32'h0000_FC00);
        hw_int = '0; timer_int = 1'b0;
        repeat (4) cyc();

        // 2. timer entry
        wr(A_ST, 32'h0000_8001);
        timer_int = 1'b1;
        wait_req(10, n);
        check("timer_latency", 32'(n), 32'd2);
        ack(32'h0000_1000, 1'b0);
        check("req_drop_on_ack", 32'(int_req), 32'h0);
        chk_reg("timer_epc", A_EP, 32'h0000_1000);
        chk_reg("timer_status", A_ST, 32'h0000_8003);
        chk_reg("timer_cause", A_CA, 32'h0000_8000);
        timer_int = 1'b0;
        repeat (2) cyc();
        do_eret(32'h0000_1000, 1'b1);
        chk_reg("timer_ret_status", A_ST, 32'h0000_8001);
        cyc();

        // 3. delay slot entry from hw_int[0]
        wr(A_ST, 32'h0000_0401);
        hw_int = 5'h01;
        wait_req(10, n);
        check("hw_latency", 32'(n), 32'd4);
        chk_reg("hw_cause_ip2", A_CA, 32'h0000_0400);
        ack(32'h0000_2004, 1'b1);
        chk_reg("bd_epc", A_EP, 32'h0000_2000);
        chk_reg("bd_cause", A_CA, 32'h8000_0400);
        hw_int = '0;
        repeat (4) cyc();
        chk_reg("bd_cause_clr", A_CA, 32'h8000_0000);

        // 4. return, then a second ERET is ignored
        do_eret(32'h0000_2000, 1'b1);
        chk_reg("ret_status", A_ST, 32'h0000_0401);
        do_eret(32'h0, 1'b0);
        repeat (2) cyc();

        // 5. withdrawal, then ack racing the withdrawing write
        hw_int = 5'h01;
        wait_req(10, n);
        check("wd_req_seen", 32'(n > 0), 32'h1);
        wr(A_ST, 32'h0000_0001);
        cyc();
        check("wd_req_fell", 32'(int_req), 32'h0);
        chk_reg("wd_epc_same", A_EP, 32'h0000_2000);
        wr(A_ST, 32'h0000_0401);
        wait_req(10, n);
        check("wd2_latency", 32'(n), 32'd1);
        reg_we = 1'b1; reg_addr = A_ST; wdata = 32'h0000_0001;
        ack(32'h0000_3000, 1'b0);
        reg_we = 1'b0;
        chk_reg("race_status", A_ST, 32'h0000_0003);
        chk_reg("race_epc", A_EP, 32'h0000_3000);
        hw_int = '0;
        repeat (4) cyc();
        do_eret(32'h0000_3000, 1'b1);
        chk_reg("race_ret_status", A_ST, 32'h0000_0001);

        // 6. software interrupt, async reset while requesting
        wr(A_ST, 32'h0000_0101);
        wr(A_CA, 32'h0000_0100);
        wait_req(10, n);
        check("sw_latency", 32'(n), 32'd1);
        #2 rst = 1'b0;
        #1 check("async_rst_req", 32'(int_req), 32'h0);
        chk_reg("async_rst_cause", A_CA, 32'h0);
        repeat (2) cyc();
        rst = 1'b1;
        repeat (2) cyc();

        // Randomized entry/return against a transaction-level EPC model
        for (int it = 0; it < 24; it++) begin
            use_timer = 1'($urandom_range(0, 1));
            pc = $urandom;
            bd = 1'($urandom_range(0, 1));
            if (it == 0) begin pc = 32'h0; bd = 1'b1; end
            if (use_timer) begin
                wr(A_ST, {16'h0, 8'h80 | 8'($urandom_range(0, 3)), 8'h01});
                timer_int = 1'b1;
                wait_req(10, n);
                check("rnd_timer_lat", 32'(n), 32'd2);
            end else begin
                wr(A_ST, {16'h0, 8'h03 | 8'($urandom_range(0, 255)), 8'h01});
                wr(A_CA, {22'h0, 2'($urandom_range(1, 3)), 8'h0});
                wait_req(10, n);
                check("rnd_sw_lat", 32'(n), 32'd1);
            end
            ack(pc, bd);
            m_epc = bd ? pc - 32'd4 : pc;
            chk_reg("rnd_epc", A_EP, m_epc);
            rd(A_CA, d);
            check("rnd_bd", 32'(d[31]), 32'(bd));
            timer_int = 1'b0;
            wr(A_CA, 32'h0);
            if ($urandom_range(0, 3) == 0) begin
                m_epc = $urandom;
                wr(A_EP, m_epc);
            end
            cyc();
            do_eret(m_epc, 1'b1);
            rd(A_ST, d);
            check("rnd_exl_clr", 32'(d[1]), 32'h0);
            cyc();
        end

        repeat (3) cyc();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
